// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder stage.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_stage_if.sv
// Bit-pair input channel and word-result output channel of the serial adder stage.
interface serial_adder_stage_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic             in_a;
    logic             in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             busy;
    logic             sync_err;

    // The producer of bit pairs, which is also the consumer of results.
    modport master (
        output in_valid, in_first, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, busy, sync_err
    );

    // The adder stage itself.
    modport slave (
        input  in_valid, in_first, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_carry, busy, sync_err
    );
endinterface

// File: rtl/serial_adder_stage_full_adder_cell.sv
// One-bit full adder; driving cin=0 gives a half adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder_stage.sv
// Bit-serial adder: accepts operands LSB-first, one bit pair per beat, and
// presents the assembled sum and final carry on a valid/ready output.
module serial_adder_stage
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input logic                clk,
    input logic                rst_n,
    serial_adder_stage_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             carry;
    logic [WIDTH-1:0] sreg;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_carry_q;
    logic             sync_err_q;

    logic             accept;
    logic             restart;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic [CNT_W-1:0] bit_idx;
    logic [WIDTH-1:0] next_word;

    assign bus.in_ready  = (state != DONE);
    assign bus.busy      = (state == SHIFT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_carry = out_carry_q;
    assign bus.sync_err  = sync_err_q;

    assign accept  = bus.in_valid && bus.in_ready;
    // A first-flagged beat always lands in bit 0 with no carry in, even mid-word.
    assign restart = bus.in_first;
    assign fa_cin  = restart ? 1'b0 : carry;
    assign bit_idx = restart ? '0 : count;

    full_adder_cell u_fa (
        .a   (bus.in_a),
        .b   (bus.in_b),
        .cin (fa_cin),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    // NOTE: every always_comb output gets a full default before any partial
    // update, otherwise synthesis infers a latch to hold the untouched bits.
    always_comb begin
        next_word          = restart ? '0 : sreg;
        next_word[bit_idx] = fa_sum;
    end

    // NOTE: state and outputs all use non-blocking assignments and are cleared
    // by the synchronous reset; there is no memory array that would need it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            carry       <= 1'b0;
            sreg        <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            sync_err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.in_first) begin
                            sreg  <= next_word;
                            carry <= fa_cout;
                            count <= CNT_W'(1);
                            state <= SHIFT;
                        end else begin
                            sync_err_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        sreg  <= next_word;
                        carry <= fa_cout;
                        if (bus.in_first) begin
                            sync_err_q <= 1'b1;
                            count      <= CNT_W'(1);
                        end else if (count == LAST_BIT) begin
                            out_sum_q   <= next_word;
                            out_carry_q <= fa_cout;
                            out_valid_q <= 1'b1;
                            count       <= '0;
                            state       <= DONE;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        carry       <= 1'b0;
                        count       <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_stage.sv
// Self-checking bench for serial_adder_stage: directed scenarios plus random
// words checked against plain integer addition.
module tb_serial_adder_stage;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks      = 0;
    int   errors      = 0;
    int   sync_pulses = 0;

    serial_adder_stage_if #(.WIDTH(W)) bus ();

    serial_adder_stage #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && bus.sync_err === 1'b1) sync_pulses++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_beat(input logic a, input logic b, input logic first);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_first = first;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    // Streams one word LSB-first; returns on the first negedge after bit W-1 is accepted.
    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
        for (int i = 0; i < W; i++) begin
            drive_beat(a[i], b[i], i == 0);
            check("in_ready_during_word", bus.in_ready, 1);
            if (i < W - 1) begin
                for (int g = 0; g < gap; g++) begin
                    idle_cycle();
                    check("busy_in_gap", bus.busy, 1);
                end
            end
        end
        idle_cycle();
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] r;
        r = ref_add(a, b);
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_sum"}, bus.out_sum, r[W-1:0]);
        check({tag, "_carry"}, bus.out_carry, r[W]);
        check({tag, "_in_ready_low"}, bus.in_ready, 0);
        check({tag, "_busy_low"}, bus.busy, 0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   rr;
        int           s0;
        int           d;
        int           gap;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_a      = 1'b0;
        bus.in_b      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_carry", bus.out_carry, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sync_err", bus.sync_err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // Back-to-back beats, consumer always ready.
        s0 = sync_pulses;
        send_word(8'h5A, 8'h3C, 0);
        check_result("b2b", 8'h5A, 8'h3C);
        idle_cycle();
        check("b2b_valid_drop", bus.out_valid, 0);
        check("b2b_in_ready_back", bus.in_ready, 1);
        check("b2b_sum_held", bus.out_sum, 8'h96);
        check("b2b_no_sync_err", sync_pulses - s0, 0);

        // Gaps of three idle cycles between beats.
        send_word(8'hFF, 8'h01, 3);
        check_result("gaps", 8'hFF, 8'h01);
        idle_cycle();
        check("gaps_valid_drop", bus.out_valid, 0);

        // Backpressure; beats offered while the result waits must be ignored.
        bus.out_ready = 1'b0;
        s0 = sync_pulses;
        send_word(8'h0F, 8'h0F, 0);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", bus.out_valid, 1);
            check("bp_sum_stable", bus.out_sum, 8'h1E);
            check("bp_in_ready_low", bus.in_ready, 0);
            drive_beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        check("bp_sum_final", bus.out_sum, 8'h1E);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        idle_cycle();
        check("bp_valid_drop", bus.out_valid, 0);
        check("bp_in_ready_back", bus.in_ready, 1);
        check("bp_no_sync_err", sync_pulses - s0, 0);

        // Framing: restart at beat 4, then a full word 0x01+0x01.
        ra = 8'($urandom);
        rb = 8'($urandom);
        s0 = sync_pulses;
        for (int i = 0; i < 4; i++) drive_beat(ra[i], rb[i], i == 0);
        send_word(8'h01, 8'h01, 0);
        check_result("restart", 8'h01, 8'h01);
        idle_cycle();
        check("restart_one_sync_err", sync_pulses - s0, 1);

        // Beat without in_first while idle is dropped with a one-cycle pulse.
        drive_beat(1'b1, 1'b1, 1'b0);
        idle_cycle();
        check("drop_sync_err_pulse", bus.sync_err, 1);
        check("drop_stays_idle", bus.busy, 0);
        idle_cycle();
        check("drop_sync_err_clears", bus.sync_err, 0);
        check("drop_no_result", bus.out_valid, 0);

        // Reset on beat 5 of a word, then a fresh word.
        ra = 8'($urandom);
        rb = 8'($urandom);
        for (int i = 0; i < 5; i++) drive_beat(ra[i], rb[i], i == 0);
        drive_beat(ra[5], rb[5], 1'b0);
        rst_n = 1'b0;
        idle_cycle();
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_sum", bus.out_sum, 0);
        check("midrst_out_carry", bus.out_carry, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_sync_err", bus.sync_err, 0);
        rst_n = 1'b1;
        idle_cycle();
        check("midrst_no_stale", bus.out_valid, 0);
        send_word(8'h80, 8'h80, 0);
        check_result("after_rst", 8'h80, 8'h80);
        idle_cycle();

        // Reset while a result is waiting.
        bus.out_ready = 1'b0;
        ra = 8'hA5;
        rb = 8'($urandom_range(0, 31));
        send_word(ra, rb, 1);
        check_result("done_rst_pre", ra, rb);
        rst_n = 1'b0;
        idle_cycle();
        check("done_rst_valid", bus.out_valid, 0);
        check("done_rst_sum", bus.out_sum, 0);
        check("done_rst_carry", bus.out_carry, 0);
        check("done_rst_in_ready", bus.in_ready, 1);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        idle_cycle();

        // Random words with random gaps and consumer stalls.
        for (int n = 0; n < 24; n++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rr  = ref_add(ra, rb);
            d   = $urandom_range(0, 3);
            gap = $urandom_range(0, 2);
            bus.out_ready = (d == 0);
            send_word(ra, rb, gap);
            check_result("rand", ra, rb);
            for (int k = 0; k < d; k++) begin
                idle_cycle();
                check("rand_hold_valid", bus.out_valid, 1);
                check("rand_hold_sum", bus.out_sum, rr[W-1:0]);
            end
            bus.out_ready = 1'b1;
            idle_cycle();
            check("rand_valid_drop", bus.out_valid, 0);
            check("rand_in_ready_back", bus.in_ready, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
